fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage: owns the PC, reads a word-addressed synchronous instruction memory,
//  and buffers fetched words in a small FIFO toward decode with a valid/ready handshake.
//  Supports branch/jump redirect with flush of buffered and in-flight fetches.
//  Sits between the branch-resolution logic (redirect source) and the decode stage.
// PARAMETERS
//  XLEN       32  data/address width in bits
//  DEPTH      64  instruction memory depth in XLEN-bit words (power of 2 not required)
//  RESET_PC   0   PC value loaded on reset
//  BUF_DEPTH  2   fetch FIFO entries (>=2)
// PORTS
//  clk            in   1           clock, all state updates on posedge
//  rst            in   1           synchronous, active-high reset
//  imem_we        in   1           loader write enable into instruction memory
//  imem_waddr     in   $clog2(DEPTH)  loader word address
//  imem_wdata     in   XLEN        loader write data
//  redirect_valid in   1           redirect request (taken branch/jump/trap)
//  redirect_pc    in   XLEN        redirect target byte address
//  inst_valid     out  1           FIFO head valid toward decode
//  inst_ready     in   1           decode accepts head when inst_valid && inst_ready
//  inst_data      out  XLEN        instruction word at head
//  inst_pc        out  XLEN        byte PC of inst_data
//  inst_fault     out  2           fetch_fault_e of head (NONE when FETCH_FAULT_EN undefined)
// BEHAVIOUR
//  Reset: pc=RESET_PC, FIFO empty, in-flight cleared; inst_valid=0, inst_data=0, inst_pc=0, inst_fault=NONE.
//  Memory contents are NOT cleared by rst.
//  Issue: in cycle C, a read of mem[pc>>2] is issued iff count + inflight - pop < BUF_DEPTH,
//  where pop = inst_valid & inst_ready; on issue pc <= pc + 4 (modulo 2^XLEN, wraps).
//  Latency: data issued in cycle C is written into the FIFO at the edge ending C; inst_valid=1 in C+1.
//  Steady state with inst_ready=1: one instruction per cycle, no bubbles.
//  First inst_valid occurs 2 cycles after the edge at which rst deasserts.
//  Backpressure: inst_ready=0 holds the head stable (inst_data/inst_pc/inst_fault unchanged);
//  issue stops once the credit rule fails. No overflow is possible.
//  Redirect (priority over everything except rst): in the redirect_valid cycle, inst_valid is forced 0
//  (no handshake completes). At the edge: FIFO flushed, any in-flight read discarded, pc <= redirect_pc.
//  First target instruction is valid 2 cycles after the redirect cycle. Back-to-back redirects: last one wins.
//  Memory: single write port, single sync read port. Read-first on same-address write/read in one cycle
//  (read returns old word). Writes are allowed during rst.
//  Reset mid-operation discards FIFO and in-flight data with no further inst_valid until refetch.
//  Address index: pc[$clog2(DEPTH)+1:2]; pc[1:0] ignored when FETCH_FAULT_EN is undefined.
// CONFIGURATION
//  FETCH_FAULT_EN defined:
//   pc[1:0]!=0 -> MISALIGNED; (pc>>2)>=DEPTH -> OUT_OF_RANGE.
//   A faulting fetch enqueues NOP_INST (0x00000013) with the fault code and its pc, then issue halts
//   (pc frozen) until a redirect.
//  FETCH_FAULT_EN undefined:
//   No checks. Out-of-range indices wrap modulo DEPTH. inst_fault is tied to NONE.
// STRUCTURE
//  Package fetch_pkg:
//   NOP_INST constant.
//   typedef enum logic[1:0] fetch_fault_e {FAULT_NONE, FAULT_MISALIGNED, FAULT_OUT_OF_RANGE}.
//   typedef struct fetch_entry_t {inst, pc, fault}.
//  Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t, depth BUF_DEPTH.
//   Ports: push, pop, flush; outputs count, head.
//  fetch_unit owns the PC, memory array, in-flight/credit logic, and fault logic.
// TESTING
//  Load mem[0..7] = 0x100+i; reset; ready=1 -> inst_pc 0,4,8,... one per cycle starting 2 cycles after reset release.
//  ready=0 for 5 cycles mid-stream -> head held stable, count saturates at BUF_DEPTH, no word lost or duplicated on release.
//  Redirect to 0x10 while FIFO is full and a read is in flight -> no stale word delivered; next valid is pc=0x10, data=0x104, 2 cycles later.
//  Redirect asserted together with a valid&ready handshake -> inst_valid low that cycle; the stale instruction is never accepted.
//  FETCH_FAULT_EN defined: redirect to 0x6 -> NOP, fault=MISALIGNED, pc=0x6, fetch halts; redirect to 4*DEPTH -> OUT_OF_RANGE.
//  Write mem[3]=0xDEAD in the same cycle pc=0xC is issued -> old word delivered; the refetch after a redirect to 0xC returns 0xDEAD.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: fault codes, the NOP used for
// faulting fetches, the default 32-bit fetch-buffer entry and the fetch state.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE         = 2'd0,
    FAULT_MISALIGNED   = 2'd1,
    FAULT_OUT_OF_RANGE = 2'd2
  } fetch_fault_e;

  typedef struct packed {
    logic [31:0]  inst;
    logic [31:0]  pc;
    fetch_fault_e fault;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries between the fetch stage and decode.
// Flush empties the queue in one cycle; storage is cleared only by rst.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     din,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output entry_t                     head
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t          store [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop  = pop & (count != '0) & ~flush;
    // A push into a full queue is accepted only when the head leaves in the same cycle.
    do_push = push & ~flush & ((count != CW'(DEPTH)) | do_pop);
  end

  assign head = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= din;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, word-addressed instruction memory, credit-based
// issue into fetch_buffer, redirect/flush. Optional fault checks: FETCH_FAULT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     imem_we,
  input  logic [$clog2(DEPTH)-1:0] imem_waddr,
  input  logic [XLEN-1:0]          imem_wdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [XLEN-1:0]          inst_data,
  output logic [XLEN-1:0]          inst_pc,
  output logic [1:0]               inst_fault
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned CW         = $clog2(BUF_DEPTH + 1);
  localparam bit          DEPTH_POW2 = ((1 << AW) == DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    fetch_fault_e    fault;
  } fetch_word_t;

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nx;
  fetch_state_e    state;
  fetch_state_e    state_nx;

  logic [XLEN-1:0] word;
  logic [AW-1:0]   rd_idx;
  fetch_fault_e    fault;
  logic            pop;
  logic            issue;
  logic [CW-1:0]   count;
  fetch_word_t     push_entry;
  fetch_word_t     head;

  if (DEPTH_POW2) begin : g_wr_pow2
    always_ff @(posedge clk) begin
      if (imem_we) begin
        mem[imem_waddr] <= imem_wdata;
      end
    end
  end else begin : g_wr_guard
    always_ff @(posedge clk) begin
      if (imem_we && (32'(imem_waddr) < DEPTH)) begin
        mem[imem_waddr] <= imem_wdata;
      end
    end
  end

  always_comb begin
    word   = pc >> 2;
    rd_idx = AW'(word % XLEN'(DEPTH));
    fault  = FAULT_NONE;
`ifdef FETCH_FAULT_EN
    if (pc[1:0] != 2'b00) begin
      fault = FAULT_MISALIGNED;
    end else if (word >= XLEN'(DEPTH)) begin
      fault = FAULT_OUT_OF_RANGE;
    end
`endif
  end

  // The synchronous read lands directly in the FIFO at the edge closing the issue
  // cycle, so the only in-flight read is the current one; redirect drops it via flush.
  always_comb begin
    inst_valid = (count != '0) & ~redirect_valid & ~rst;
    pop        = inst_valid & inst_ready;
    issue      = ~redirect_valid & (state == ST_RUN)
               & ((count < CW'(BUF_DEPTH)) | pop);

    push_entry.inst  = (fault == FAULT_NONE) ? mem[rd_idx] : XLEN'(NOP_INST);
    push_entry.pc    = pc;
    push_entry.fault = fault;

    pc_nx    = pc;
    state_nx = state;
    if (redirect_valid) begin
      pc_nx    = redirect_pc;
      state_nx = ST_RUN;
    end else if (issue) begin
      if (fault != FAULT_NONE) begin
        state_nx = ST_HALT;
      end else begin
        pc_nx = pc + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else begin
      pc    <= pc_nx;
      state <= state_nx;
    end
  end

  fetch_buffer #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (fetch_word_t)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .count (count),
    .head  (head)
  );

  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;
  assign inst_fault = head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit (default parameters).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [1:0]  inst_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN      (32),
    .DEPTH     (64),
    .RESET_PC  (32'h0),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  typedef struct {
    bit          rst;
    bit          we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    bit          ready;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] edata;
    logic [1:0]  efault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input bit r, input bit we, input logic [5:0] wa,
                               input logic [31:0] wd, input bit rdy, input bit rv,
                               input logic [31:0] rpc, input bit ev, input logic [31:0] epc,
                               input logic [31:0] ed, input logic [1:0] ef);
    vec_t v;
    v.rst = r; v.we = we; v.waddr = wa; v.wdata = wd;
    v.ready = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.edata = ed; v.efault = ef;
    return v;
  endfunction

  // Normal-operation vector: no reset, no memory write, fault NONE expected.
  function automatic vec_t nv(input bit rdy, input bit rv, input logic [31:0] rpc,
                              input bit ev, input logic [31:0] epc, input logic [31:0] ed);
    return mkv(1'b0, 1'b0, 6'd0, 32'd0, rdy, rv, rpc, ev, epc, ed, 2'd0);
  endfunction

  task automatic chk(input string what, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h exp=%h", what, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst            = v.rst;
    imem_we        = v.we;
    imem_waddr     = v.waddr;
    imem_wdata     = v.wdata;
    inst_ready     = v.ready;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    #1;
    chk("inst_valid", idx, 32'(inst_valid), 32'(v.ev));
    if (v.ev) begin
      chk("inst_pc", idx, inst_pc, v.epc);
      chk("inst_data", idx, inst_data, v.edata);
      chk("inst_fault", idx, 32'(inst_fault), 32'(v.efault));
    end
  endtask

  initial begin
    rst = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Load memory while held in reset.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_waddr = 6'(i);
      imem_wdata = 32'h100 + 32'(i);
    end
    @(negedge clk);
    imem_we = 1'b0;
    #1;
    chk("rst_valid", -1, 32'(inst_valid), 32'd0);
    chk("rst_data",  -1, inst_data, 32'd0);
    chk("rst_pc",    -1, inst_pc, 32'd0);
    chk("rst_fault", -1, 32'(inst_fault), 32'd0);

    // Release, streaming, 5-cycle backpressure.
    vecs.push_back(nv(1, 0, 0, 0, 32'h00, 32'h000));
    vecs.push_back(nv(1, 0, 0, 1, 32'h00, 32'h100));
    vecs.push_back(nv(1, 0, 0, 1, 32'h04, 32'h101));
    vecs.push_back(nv(1, 0, 0, 1, 32'h08, 32'h102));
    for (int i = 0; i < 5; i++) vecs.push_back(nv(0, 0, 0, 1, 32'h0C, 32'h103));
    vecs.push_back(nv(1, 0, 0, 1, 32'h0C, 32'h103));
    vecs.push_back(nv(1, 0, 0, 1, 32'h10, 32'h104));
    vecs.push_back(nv(1, 0, 0, 1, 32'h14, 32'h105));
    vecs.push_back(nv(1, 0, 0, 1, 32'h18, 32'h106));
    // Fill the FIFO, then redirect to 0x10.
    vecs.push_back(nv(0, 0, 0, 1, 32'h1C, 32'h107));
    vecs.push_back(nv(0, 1, 32'h10, 0, 0, 0));
    vecs.push_back(nv(1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(1, 0, 0, 1, 32'h10, 32'h104));
    vecs.push_back(nv(1, 0, 0, 1, 32'h14, 32'h105));
    // Redirect coincident with a would-be handshake.
    vecs.push_back(nv(1, 1, 32'h40, 0, 0, 0));
    vecs.push_back(nv(1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(1, 0, 0, 1, 32'h40, 32'h110));
    vecs.push_back(nv(1, 0, 0, 1, 32'h44, 32'h111));
    // Back-to-back redirects: last one wins.
    vecs.push_back(nv(1, 1, 32'h80, 0, 0, 0));
    vecs.push_back(nv(1, 1, 32'h20, 0, 0, 0));
    vecs.push_back(nv(1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(1, 0, 0, 1, 32'h20, 32'h108));
    vecs.push_back(nv(1, 0, 0, 1, 32'h24, 32'h109));
    // Mid-stream reset; memory contents survive.
    vecs.push_back(mkv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nv(1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(1, 0, 0, 1, 32'h00, 32'h100));
    vecs.push_back(nv(1, 0, 0, 1, 32'h04, 32'h101));
    // Write mem[3] in the cycle pc=0xC issues: old word comes out, refetch sees new.
    vecs.push_back(mkv(0, 1, 6'd3, 32'hDEAD, 1, 0, 0, 1, 32'h08, 32'h102, 0));
    vecs.push_back(nv(1, 0, 0, 1, 32'h0C, 32'h103));
    vecs.push_back(nv(1, 1, 32'h0C, 0, 0, 0));
    vecs.push_back(nv(1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(1, 0, 0, 1, 32'h0C, 32'hDEAD));
    vecs.push_back(nv(1, 0, 0, 1, 32'h10, 32'h104));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifdef FETCH_FAULT_EN
    // Misaligned target: NOP with fault, then fetch halts until redirect.
    apply(nv(1, 1, 32'h6, 0, 0, 0), 100);
    apply(nv(1, 0, 0, 0, 0, 0), 101);
    apply(mkv(0, 0, 0, 0, 1, 0, 0, 1, 32'h6, 32'h13, 2'd1), 102);
    apply(nv(1, 0, 0, 0, 0, 0), 103);
    apply(nv(1, 0, 0, 0, 0, 0), 104);
    // Word index == DEPTH is out of range.
    apply(nv(1, 1, 32'h100, 0, 0, 0), 105);
    apply(nv(1, 0, 0, 0, 0, 0), 106);
    apply(mkv(0, 0, 0, 0, 1, 0, 0, 1, 32'h100, 32'h13, 2'd2), 107);
    apply(nv(1, 0, 0, 0, 0, 0), 108);
    // Recovery by redirect.
    apply(nv(1, 1, 32'h8, 0, 0, 0), 109);
    apply(nv(1, 0, 0, 0, 0, 0), 110);
    apply(nv(1, 0, 0, 1, 32'h8, 32'h102), 111);
`else
    // Last word, then index wraps modulo DEPTH.
    apply(nv(1, 1, 32'hFC, 0, 0, 0), 100);
    apply(nv(1, 0, 0, 0, 0, 0), 101);
    apply(nv(1, 0, 0, 1, 32'hFC, 32'h13F), 102);
    apply(nv(1, 0, 0, 1, 32'h100, 32'h100), 103);
    apply(nv(1, 0, 0, 1, 32'h104, 32'h101), 104);
    // Unaligned pc is accepted without a fault; low bits ignored.
    apply(nv(1, 1, 32'h6, 0, 0, 0), 105);
    apply(nv(1, 0, 0, 0, 0, 0), 106);
    apply(nv(1, 0, 0, 1, 32'h6, 32'h101), 107);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
